dma_csr_tl_slave: RTL
=====================

Name: dma_csr_tl_slave

Overview:
TileLink-UL register slave that programs and monitors the single-channel DMA engine. It sits directly upstream of the DMA core: the CPU writes source, destination, length and max beat size over TL-UL, writes START, and this block pulses the core's transfer request and holds its configuration stable. It then captures the core's done/error indications into sticky status bits and raises an optional level interrupt.

Parameters:
SOURCE_W, 1, width of the TL a_source/d_source fields (echoed unchanged)

Ports:
dmac_clock_i  in  1  clock; all logic on the rising edge
dmac_resetn_i  in  1  reset; asynchronous, active-low
csr_a_opcode  in  3  TL A opcode: 0 PutFull, 1 PutPartial, 4 Get
csr_a_param  in  3  ignored
csr_a_size  in  4  ignored except echoed; must be ≤2
csr_a_source  in  SOURCE_W  request id
csr_a_address  in  32  byte address; only bits [4:2] decoded
csr_a_mask  in  4  byte lanes for Put
csr_a_data  in  32  write data
csr_a_valid  in  1  request valid
csr_a_ready  out  1  request accept
csr_d_opcode  out  3  0 AccessAck, 1 AccessAckData
csr_d_param  out  2  always 0
csr_d_size  out  4  echoed a_size
csr_d_source  out  SOURCE_W  echoed a_source
csr_d_denied  out  1  request rejected
csr_d_data  out  32  read data; 0 for non-Get or denied responses
csr_d_corrupt  out  1  always 0
csr_d_valid  out  1  response valid
csr_d_ready  in  1  response accept
dmac_tx_o  out  1  one-cycle start pulse to the core
dmac_source_address_o  out  32  SRC register
dmac_dest_address_o  out  32  DST register
dmac_bytes_tx_o  out  32  LEN register
dmac_max_size_o  out  2  CTRL.MAX_SIZE
dmac_busy_i  in  1  core busy
dmac_done_i  in  1  core done indication
dmac_err_i  in  1  core error, valid while done is high
irq_o  out  1  level interrupt = IRQ_EN & (DONE | ERR)

Behaviour:
- Register map (offset from a_address[4:2]):
  - 0x00 CTRL: bit0 START, write-1 action, reads 0. bit1 IRQ_EN, RW. bits[3:2] MAX_SIZE, RW.
  - 0x04 SRC, RW.
  - 0x08 DST, RW.
  - 0x0C LEN, RW.
  - 0x10 STATUS: bit0 BUSY, RO. bit1 DONE, sticky, W1C. bit2 ERR, sticky, W1C.
  - 0x14–0x1C: denied.
- Reset: all registers 0, dmac_tx_o 0, csr_d_valid 0, irq_o 0, edge-detect flop 0.
- Effective busy: eb = dmac_busy_i | dmac_tx_o. This covers the cycle before the core raises busy.
- TL handshake:
  - Single outstanding request.
  - csr_a_ready = ~csr_d_valid.
  - A request is accepted when valid & ready. The response is registered, so csr_d_valid rises the cycle after acceptance.
  - Response fields hold until csr_d_valid & csr_d_ready, then d_valid clears. Back-to-back throughput is therefore one request per 2 cycles.
- Opcode handling:
  - Get → AccessAckData.
  - PutFull or PutPartial → AccessAck. The write applies only to byte lanes set in a_mask.
  - Any other opcode → AccessAck with denied=1, no side effect.
- Denied requests (no side effect at all):
  - Unmapped offset. Get gets d_opcode AccessAckData, Put gets AccessAck.
  - A Put to CTRL, SRC, DST or LEN while eb=1. The whole write is rejected, including IRQ_EN.
- STATUS writes are never denied.
- START: a write to CTRL with lane 0 enabled, data bit0=1 and eb=0 drives dmac_tx_o=1 for exactly the next cycle. Fields written in the same access are visible on the dmac_*_o outputs in that same cycle.
- Done capture:
  - done_rise = dmac_done_i & ~done_q, where done_q is a registered copy of dmac_done_i.
  - On done_rise: DONE←1, and ERR←ERR|dmac_err_i.
  - If a W1C to a bit coincides with a capture that sets it, the set wins.
- BUSY read reflects eb.
- irq_o is registered, so it updates one cycle after DONE/ERR/IRQ_EN change.
- Reset asserted mid-transfer clears all CSRs immediately. The core is not reset by this block.

Test Plan:
- Write SRC=0x1000, DST=0x2000, LEN=8, then CTRL=0x0B (START, IRQ_EN, MAX_SIZE=2) → dmac_tx_o high exactly 1 cycle, outputs hold 0x1000/0x2000/8/2. Read STATUS → 0x1 while busy.
- Model the core: busy for 20 cycles, then done=1, err=0 for 1 cycle → STATUS=0x2, irq_o=1 one cycle later. Write STATUS=0x2 → STATUS=0x0, irq_o falls.
- Core reports done with err=1 → STATUS=0x6. W1C of DONE coinciding with a second done_rise → DONE stays 1.
- While busy, Put SRC=0xDEAD and Put CTRL=0x1 → both responses denied=1, SRC unchanged, no tx pulse. Get SRC → not denied.
- PutPartial to LEN with mask=0x2, data=0x0000AB00, over LEN=0x11223344 → LEN=0x1122AB44. Get 0x18 → AccessAckData, denied=1, data=0.
- Hold csr_d_ready=0 for 5 cycles → a_ready stays 0 and the d fields are stable. Assert dmac_resetn_i mid-response → d_valid drops asynchronously, all CSRs read 0 after release.

Source files
------------

// File: rtl/dma_csr_tl_slave_if.sv
// TL-UL A/D channel bundle between a CPU-side master and the DMA CSR slave.
interface dma_csr_tl_slave_if #(parameter int SOURCE_W = 1);
  logic [2:0]          csr_a_opcode;
  logic [2:0]          csr_a_param;
  logic [3:0]          csr_a_size;
  logic [SOURCE_W-1:0] csr_a_source;
  logic [31:0]         csr_a_address;
  logic [3:0]          csr_a_mask;
  logic [31:0]         csr_a_data;
  logic                csr_a_valid;
  logic                csr_a_ready;
  logic [2:0]          csr_d_opcode;
  logic [1:0]          csr_d_param;
  logic [3:0]          csr_d_size;
  logic [SOURCE_W-1:0] csr_d_source;
  logic                csr_d_denied;
  logic [31:0]         csr_d_data;
  logic                csr_d_corrupt;
  logic                csr_d_valid;
  logic                csr_d_ready;

  modport master (
    output csr_a_opcode, csr_a_param, csr_a_size, csr_a_source, csr_a_address,
           csr_a_mask, csr_a_data, csr_a_valid, csr_d_ready,
    input  csr_a_ready, csr_d_opcode, csr_d_param, csr_d_size, csr_d_source,
           csr_d_denied, csr_d_data, csr_d_corrupt, csr_d_valid
  );

  modport slave (
    input  csr_a_opcode, csr_a_param, csr_a_size, csr_a_source, csr_a_address,
           csr_a_mask, csr_a_data, csr_a_valid, csr_d_ready,
    output csr_a_ready, csr_d_opcode, csr_d_param, csr_d_size, csr_d_source,
           csr_d_denied, csr_d_data, csr_d_corrupt, csr_d_valid
  );
endinterface

// File: rtl/dma_csr_tl_slave.sv
// TL-UL CSR slave for the single-channel DMA: config registers, start pulse,
// sticky done/error capture and level interrupt.
module dma_csr_tl_slave #(
  parameter int SOURCE_W = 1
) (
  input  logic                   dmac_clock_i,
  input  logic                   dmac_resetn_i,
  dma_csr_tl_slave_if.slave      tl,
  output logic                   dmac_tx_o,
  output logic [31:0]            dmac_source_address_o,
  output logic [31:0]            dmac_dest_address_o,
  output logic [31:0]            dmac_bytes_tx_o,
  output logic [1:0]             dmac_max_size_o,
  input  logic                   dmac_busy_i,
  input  logic                   dmac_done_i,
  input  logic                   dmac_err_i,
  output logic                   irq_o
);

  localparam logic [2:0] OP_PUT_F = 3'd0, OP_PUT_P = 3'd1, OP_GET = 3'd4;
  localparam logic [2:0] D_ACK = 3'd0, D_ACK_DATA = 3'd1;
  localparam logic [2:0] OFF_CTRL = 3'd0, OFF_SRC = 3'd1, OFF_DST = 3'd2,
                         OFF_LEN = 3'd3, OFF_STATUS = 3'd4;

  logic                irq_en_q, irq_en_d;
  logic [1:0]          max_size_q, max_size_d;
  logic [31:0]         src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic                done_st_q, done_st_d, err_st_q, err_st_d;
  logic                done_q, done_d;
  logic                tx_q, tx_d;
  logic                irq_q, irq_d;
  logic                d_valid_q, d_valid_d;
  logic [2:0]          d_opcode_q, d_opcode_d;
  logic [3:0]          d_size_q, d_size_d;
  logic [SOURCE_W-1:0] d_source_q, d_source_d;
  logic                d_denied_q, d_denied_d;
  logic [31:0]         d_data_q, d_data_d;

  logic       eb, accept, is_get, is_put, mapped, locked, denied, wr, done_rise;
  logic [2:0] off;
  logic [31:0] rdata;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  mask);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (mask[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  // The start pulse counts as busy so a second START cannot slip in before
  // the core raises its own busy.
  assign eb        = dmac_busy_i | tx_q;
  assign accept    = tl.csr_a_valid & ~d_valid_q;
  assign off       = tl.csr_a_address[4:2];
  assign is_get    = (tl.csr_a_opcode == OP_GET);
  assign is_put    = (tl.csr_a_opcode == OP_PUT_F) | (tl.csr_a_opcode == OP_PUT_P);
  assign mapped    = (off <= OFF_STATUS);
  assign locked    = is_put & (off != OFF_STATUS) & eb;
  assign denied    = ~(is_get | is_put) | ~mapped | locked;
  assign wr        = accept & is_put & ~denied;
  assign done_rise = dmac_done_i & ~done_q;

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:   rdata = {28'd0, max_size_q, irq_en_q, 1'b0};
      OFF_SRC:    rdata = src_q;
      OFF_DST:    rdata = dst_q;
      OFF_LEN:    rdata = len_q;
      OFF_STATUS: rdata = {29'd0, err_st_q, done_st_q, eb};
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    irq_en_d   = irq_en_q;
    max_size_d = max_size_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    done_st_d  = done_st_q;
    err_st_d   = err_st_q;
    done_d     = dmac_done_i;
    tx_d       = 1'b0;
    irq_d      = irq_en_q & (done_st_q | err_st_q);
    d_valid_d  = d_valid_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_denied_d = d_denied_q;
    d_data_d   = d_data_q;

    if (d_valid_q & tl.csr_d_ready) d_valid_d = 1'b0;

    if (accept) begin
      d_valid_d  = 1'b1;
      d_opcode_d = is_get ? D_ACK_DATA : D_ACK;
      d_size_d   = tl.csr_a_size;
      d_source_d = tl.csr_a_source;
      d_denied_d = denied;
      d_data_d   = (is_get & ~denied) ? rdata : 32'd0;
    end

    if (wr) begin
      case (off)
        OFF_CTRL: if (tl.csr_a_mask[0]) begin
          irq_en_d   = tl.csr_a_data[1];
          max_size_d = tl.csr_a_data[3:2];
          tx_d       = tl.csr_a_data[0];
        end
        OFF_SRC: src_d = merge(src_q, tl.csr_a_data, tl.csr_a_mask);
        OFF_DST: dst_d = merge(dst_q, tl.csr_a_data, tl.csr_a_mask);
        OFF_LEN: len_d = merge(len_q, tl.csr_a_data, tl.csr_a_mask);
        OFF_STATUS: if (tl.csr_a_mask[0]) begin
          if (tl.csr_a_data[1]) done_st_d = 1'b0;
          if (tl.csr_a_data[2]) err_st_d  = 1'b0;
        end
        default: ;
      endcase
    end

    // Capture after the W1C so a coincident completion is never lost.
    if (done_rise) begin
      done_st_d = 1'b1;
      if (dmac_err_i) err_st_d = 1'b1;
    end
  end

  always_ff @(posedge dmac_clock_i or negedge dmac_resetn_i) begin
    if (!dmac_resetn_i) begin
      irq_en_q   <= 1'b0;
      max_size_q <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      done_st_q  <= 1'b0;
      err_st_q   <= 1'b0;
      done_q     <= 1'b0;
      tx_q       <= 1'b0;
      irq_q      <= 1'b0;
      d_valid_q  <= 1'b0;
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_denied_q <= 1'b0;
      d_data_q   <= '0;
    end else begin
      irq_en_q   <= irq_en_d;
      max_size_q <= max_size_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      done_st_q  <= done_st_d;
      err_st_q   <= err_st_d;
      done_q     <= done_d;
      tx_q       <= tx_d;
      irq_q      <= irq_d;
      d_valid_q  <= d_valid_d;
      d_opcode_q <= d_opcode_d;
      d_size_q   <= d_size_d;
      d_source_q <= d_source_d;
      d_denied_q <= d_denied_d;
      d_data_q   <= d_data_d;
    end
  end

  assign tl.csr_a_ready    = ~d_valid_q;
  assign tl.csr_d_valid    = d_valid_q;
  assign tl.csr_d_opcode   = d_opcode_q;
  assign tl.csr_d_param    = 2'd0;
  assign tl.csr_d_size     = d_size_q;
  assign tl.csr_d_source   = d_source_q;
  assign tl.csr_d_denied   = d_denied_q;
  assign tl.csr_d_data     = d_data_q;
  assign tl.csr_d_corrupt  = 1'b0;

  assign dmac_tx_o             = tx_q;
  assign dmac_source_address_o = src_q;
  assign dmac_dest_address_o   = dst_q;
  assign dmac_bytes_tx_o       = len_q;
  assign dmac_max_size_o       = max_size_q;
  assign irq_o                 = irq_q;

  logic unused_sig;
  assign unused_sig = ^{tl.csr_a_param, tl.csr_a_address[31:5], tl.csr_a_address[1:0]};

endmodule
